// File: rtl/avalon_burst_splitter.sv
// ============================================================================
// avalon_burst_splitter - Avalon burst (1..4 beats) to single-beat splitter.
// Macro AO486_BURST_SPLIT_WRAP_EN: wrap beat addresses inside the 16-byte line.
// Revision: 1.0
// ============================================================================
`default_nettype none

module avalon_burst_splitter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_avs_address,
  input  logic [31:0] i_avs_writedata,
  input  logic [3:0]  i_avs_byteenable,
  input  logic [2:0]  i_avs_burstcount,
  input  logic        i_avs_write,
  input  logic        i_avs_read,
  output logic        o_avs_waitrequest,
  output logic        o_avs_readdatavalid,
  output logic [31:0] o_avs_readdata,
  output logic [31:0] o_avm_address,
  output logic [31:0] o_avm_writedata,
  output logic [3:0]  o_avm_byteenable,
  output logic        o_avm_write,
  output logic        o_avm_read,
  input  logic        i_avm_waitrequest,
  input  logic        i_avm_readdatavalid,
  input  logic [31:0] i_avm_readdata
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_ISSUE = 3'd1,
    S_WR_DATA  = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_WAIT  = 3'd4
  } state_t;

  state_t      r_state;
  logic [2:0]  r_remaining;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_avm_write;
  logic        r_avm_read;
  logic        r_rdv;
  logic [31:0] r_rdata;

  logic [2:0]  w_count;
  logic [31:0] w_start_addr;
  logic [31:0] w_next_addr;

  always_comb begin
    if (i_avs_burstcount == 3'd0)
      w_count = 3'd1;
    else if (i_avs_burstcount > 3'd4)
      w_count = 3'd4;
    else
      w_count = i_avs_burstcount;
  end

  assign w_start_addr = i_avs_address & 32'hFFFF_FFFC;

`ifdef AO486_BURST_SPLIT_WRAP_EN
  assign w_next_addr = {r_addr[31:4], r_addr[3:2] + 2'd1, 2'b00};
`else
  assign w_next_addr = r_addr + 32'd4;
`endif

  // Upstream may only present beats while idle or waiting for the next write beat.
  assign o_avs_waitrequest   = (r_state != S_IDLE) && (r_state != S_WR_DATA);
  assign o_avs_readdatavalid = r_rdv;
  assign o_avs_readdata      = r_rdata;
  assign o_avm_address       = r_addr;
  assign o_avm_writedata     = r_wdata;
  assign o_avm_byteenable    = r_be;
  assign o_avm_write         = r_avm_write;
  assign o_avm_read          = r_avm_read;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_remaining <= 3'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_be        <= 4'd0;
      r_avm_write <= 1'b0;
      r_avm_read  <= 1'b0;
      r_rdv       <= 1'b0;
      r_rdata     <= 32'd0;
    end else begin
      r_rdv <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_avs_write) begin
            r_addr      <= w_start_addr;
            r_wdata     <= i_avs_writedata;
            r_be        <= i_avs_byteenable;
            r_remaining <= w_count;
            r_avm_write <= 1'b1;
            r_state     <= S_WR_ISSUE;
          end else if (i_avs_read) begin
            r_addr      <= w_start_addr;
            r_be        <= i_avs_byteenable;
            r_remaining <= w_count;
            r_avm_read  <= 1'b1;
            r_state     <= S_RD_ISSUE;
          end
        end
        S_WR_ISSUE: begin
          if (!i_avm_waitrequest) begin
            r_avm_write <= 1'b0;
            r_remaining <= r_remaining - 3'd1;
            if (r_remaining == 3'd1) begin
              r_state <= S_IDLE;
            end else begin
              r_addr  <= w_next_addr;
              r_state <= S_WR_DATA;
            end
          end
        end
        S_WR_DATA: begin
          if (i_avs_write) begin
            r_wdata     <= i_avs_writedata;
            r_be        <= i_avs_byteenable;
            r_avm_write <= 1'b1;
            r_state     <= S_WR_ISSUE;
          end
        end
        S_RD_ISSUE: begin
          if (!i_avm_waitrequest) begin
            r_avm_read <= 1'b0;
            r_state    <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (i_avm_readdatavalid) begin
            r_rdata     <= i_avm_readdata;
            r_rdv       <= 1'b1;
            r_remaining <= r_remaining - 3'd1;
            if (r_remaining == 3'd1) begin
              r_state <= S_IDLE;
            end else begin
              // Only the first read beat honours the master's byte enables.
              r_addr     <= w_next_addr;
              r_be       <= 4'hF;
              r_avm_read <= 1'b1;
              r_state    <= S_RD_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_avalon_burst_splitter.sv
// ============================================================================
// tb_avalon_burst_splitter - directed and random bursts against a transaction model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_avalon_burst_splitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] avs_address, avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [2:0]  avs_burstcount;
  logic        avs_write, avs_read;
  logic        avs_waitrequest, avs_readdatavalid;
  logic [31:0] avs_readdata;
  logic [31:0] avm_address, avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_write, avm_read;
  logic        avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;

  always #5 clk = ~clk;

  avalon_burst_splitter dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_avs_address       (avs_address),
    .i_avs_writedata     (avs_writedata),
    .i_avs_byteenable    (avs_byteenable),
    .i_avs_burstcount    (avs_burstcount),
    .i_avs_write         (avs_write),
    .i_avs_read          (avs_read),
    .o_avs_waitrequest   (avs_waitrequest),
    .o_avs_readdatavalid (avs_readdatavalid),
    .o_avs_readdata      (avs_readdata),
    .o_avm_address       (avm_address),
    .o_avm_writedata     (avm_writedata),
    .o_avm_byteenable    (avm_byteenable),
    .o_avm_write         (avm_write),
    .o_avm_read          (avm_read),
    .i_avm_waitrequest   (avm_waitrequest),
    .i_avm_readdatavalid (avm_readdatavalid),
    .i_avm_readdata      (avm_readdata)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  // Observed downstream/upstream traffic
  logic [31:0] wr_addr_q[$], wr_data_q[$];
  logic [3:0]  wr_be_q[$];
  logic [31:0] rd_addr_q[$];
  logic [3:0]  rd_be_q[$];
  logic [31:0] rdata_q[$];
  int          rdv_cyc_q[$];
  // Expected traffic from the model
  logic [31:0] exp_wa[$], exp_wd[$], exp_ra[$], exp_rdata[$];
  logic [3:0]  exp_wbe[$], exp_rbe[$];
  // Slave read responses in flight
  int          resp_due_q[$];
  logic [31:0] resp_data_q[$];

  int          latency   = 1;
  int          stall_at  = -1;
  int          stall_left = 0;
  bit          rand_ws   = 1'b0;
  bit          prev_hold = 1'b0;
  logic [69:0] prev_snap = '0;

  function automatic int norm(input logic [2:0] bc);
    if (bc == 3'd0) return 1;
    if (bc > 3'd4) return 4;
    return int'(bc);
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a);
`ifdef AO486_BURST_SPLIT_WRAP_EN
    return (a & 32'hFFFF_FFF0) | ((a + 32'd4) & 32'h0000_000F);
`else
    return a + 32'd4;
`endif
  endfunction

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h5EED_C0DE;
  endfunction

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: act as the downstream slave, monitor both sides, advance.
  task automatic cyc();
    logic [69:0] snap;
    snap = {avm_address, avm_writedata, avm_byteenable, avm_write, avm_read};
    if (prev_hold) check("avm_stable_under_wait", snap, prev_snap);
    if (avm_write || avm_read) check("avs_wait_during_issue", 70'(avs_waitrequest), 70'(1));
    avm_waitrequest = 1'b0;
    if (avm_write || avm_read) begin
      if (avm_write && stall_left > 0 && wr_addr_q.size() == stall_at) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else if (rand_ws && $urandom_range(0, 3) == 0) begin
        avm_waitrequest = 1'b1;
      end
    end
    avm_readdatavalid = 1'b0;
    avm_readdata      = $urandom;
    if (resp_due_q.size() > 0 && resp_due_q[0] == cyc_n) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = resp_data_q[0];
      void'(resp_due_q.pop_front());
      void'(resp_data_q.pop_front());
    end
    if (avm_write && !avm_waitrequest) begin
      wr_addr_q.push_back(avm_address);
      wr_data_q.push_back(avm_writedata);
      wr_be_q.push_back(avm_byteenable);
    end
    if (avm_read && !avm_waitrequest) begin
      rd_addr_q.push_back(avm_address);
      rd_be_q.push_back(avm_byteenable);
      resp_due_q.push_back(cyc_n + latency);
      resp_data_q.push_back(mem_data(avm_address));
    end
    if (avs_readdatavalid) begin
      rdata_q.push_back(avs_readdata);
      rdv_cyc_q.push_back(cyc_n);
    end
    prev_hold = (avm_write || avm_read) && avm_waitrequest;
    prev_snap = snap;
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic wait_accept(input string tag, output int acc);
    int n = 0;
    while (avs_waitrequest && n < 60) begin
      cyc();
      n++;
    end
    check(tag, 70'(avs_waitrequest), 70'(0));
    acc = cyc_n;
    cyc();
  endtask

  task automatic wait_idle(output int when);
    int n = 0;
    while ((avs_waitrequest || avm_write || avm_read) && n < 100) begin
      cyc();
      n++;
    end
    check("idle_reached", 70'({avs_waitrequest, avm_write, avm_read}), 70'(0));
    when = cyc_n;
  endtask

  task automatic wait_rdata();
    int n = 0;
    while (rdata_q.size() < exp_rdata.size() && n < 300) begin
      cyc();
      n++;
    end
  endtask

  task automatic write_burst(input logic [31:0] a, input logic [2:0] bc, input logic [127:0] d,
                             input logic [15:0] be, output int acc, output int done);
    int nb;
    int t;
    logic [31:0] ea;
    nb  = norm(bc);
    ea  = a & 32'hFFFF_FFFC;
    acc = 0;
    for (int i = 0; i < nb; i++) begin
      exp_wa.push_back(ea);
      exp_wd.push_back(d[32*i +: 32]);
      exp_wbe.push_back(be[4*i +: 4]);
      ea = next_addr(ea);
      avs_write      = 1'b1;
      avs_writedata  = d[32*i +: 32];
      avs_byteenable = be[4*i +: 4];
      avs_address    = (i == 0) ? a : $urandom;
      avs_burstcount = (i == 0) ? bc : 3'($urandom);
      wait_accept("wr_beat_accept", t);
      if (i == 0) acc = t;
    end
    avs_write = 1'b0;
    wait_idle(done);
  endtask

  task automatic read_burst(input logic [31:0] a, input logic [2:0] bc, input logic [3:0] be,
                            input int lat, output int acc);
    int nb;
    int dummy;
    logic [31:0] ea;
    nb = norm(bc);
    ea = a & 32'hFFFF_FFFC;
    latency = lat;
    for (int i = 0; i < nb; i++) begin
      exp_ra.push_back(ea);
      exp_rbe.push_back((i == 0) ? be : 4'hF);
      exp_rdata.push_back(mem_data(ea));
      ea = next_addr(ea);
    end
    avs_read       = 1'b1;
    avs_address    = a;
    avs_burstcount = bc;
    avs_byteenable = be;
    wait_accept("rd_cmd_accept", acc);
    avs_read    = 1'b0;
    avs_address = $urandom;
    wait_rdata();
    wait_idle(dummy);
  endtask

  task automatic clear_obs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_be_q.delete();
    rd_addr_q.delete(); rd_be_q.delete();
    rdata_q.delete(); rdv_cyc_q.delete();
    exp_wa.delete(); exp_wd.delete(); exp_wbe.delete();
    exp_ra.delete(); exp_rbe.delete(); exp_rdata.delete();
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_wr_count"}, 70'(wr_addr_q.size()), 70'(exp_wa.size()));
    foreach (exp_wa[i])
      if (i < wr_addr_q.size())
        check({tag, "_wr_beat"}, {wr_addr_q[i], wr_data_q[i], wr_be_q[i], 2'b00},
              {exp_wa[i], exp_wd[i], exp_wbe[i], 2'b00});
    check({tag, "_rd_count"}, 70'(rd_addr_q.size()), 70'(exp_ra.size()));
    foreach (exp_ra[i])
      if (i < rd_addr_q.size())
        check({tag, "_rd_beat"}, 70'({rd_addr_q[i], rd_be_q[i]}), 70'({exp_ra[i], exp_rbe[i]}));
    check({tag, "_rdata_count"}, 70'(rdata_q.size()), 70'(exp_rdata.size()));
    foreach (exp_rdata[i])
      if (i < rdata_q.size())
        check({tag, "_rdata"}, 70'(rdata_q[i]), 70'(exp_rdata[i]));
    clear_obs();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, done, acc_w, acc_r, first;
    logic [31:0] ra;
    logic [2:0]  rbc;
    avs_address = '0; avs_writedata = '0; avs_byteenable = '0; avs_burstcount = '0;
    avs_write = 1'b0; avs_read = 1'b0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_avs", 70'({avs_waitrequest, avs_readdatavalid, avs_readdata}), 70'(0));
    check("reset_avm", {avm_address, avm_writedata, avm_byteenable, avm_write, avm_read}, 70'(0));
    rst_n = 1'b1;
    cyc();

    // 4-beat write, no stalls
    write_burst(32'h1008, 3'd4, {32'hD, 32'hC, 32'hB, 32'hA}, 16'hFFFF, acc, done);
    check("wr4_cycles_to_idle", 70'(done - acc), 70'(8));
    compare_all("wr4");

    // 2-beat read, latency 3
    read_burst(32'h2000, 3'd2, 4'h6, 3, acc);
    first = (rdv_cyc_q.size() > 0) ? rdv_cyc_q[0] : -1000;
    check("rd_first_valid_latency", 70'(first - acc), 70'(5));
    compare_all("rd2");

    // 5-cycle downstream stall on write beat 2
    stall_at = 1; stall_left = 5;
    write_burst(32'h5010, 3'd4, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                16'h8421, acc, done);
    check("stall_consumed", 70'(stall_left), 70'(0));
    stall_at = -1;
    compare_all("wr_stall");

    // Burstcount normalisation
    write_burst(32'h6000, 3'd0, {96'h0, 32'h0000_0C0C}, 16'h0003, acc, done);
    compare_all("bc0");
    write_burst(32'h6100, 3'd7, {32'h7777_0004, 32'h7777_0003, 32'h7777_0002, 32'h7777_0001},
                16'hF0F0, acc, done);
    compare_all("bc7");
    read_burst(32'h6200, 3'd5, 4'h1, 2, acc);
    compare_all("rd_bc5");

    // Address wrap near the top of the address space
    write_burst(32'hFFFF_FFF9, 3'd4, {32'h4, 32'h3, 32'h2, 32'h1}, 16'hFFFF, acc, done);
    compare_all("wr_top");

    // Write and read requested together: write first, read afterwards
    exp_wa.push_back(32'h3000); exp_wd.push_back(32'hCAFE_F00D); exp_wbe.push_back(4'hF);
    avs_write = 1'b1; avs_read = 1'b1; avs_address = 32'h3000; avs_burstcount = 3'd1;
    avs_writedata = 32'hCAFE_F00D; avs_byteenable = 4'hF;
    wait_accept("both_wr_accept", acc_w);
    avs_write = 1'b0; avs_address = 32'h4000; avs_burstcount = 3'd2; avs_byteenable = 4'h9;
    latency = 2;
    exp_ra.push_back(32'h4000); exp_rbe.push_back(4'h9); exp_rdata.push_back(mem_data(32'h4000));
    exp_ra.push_back(next_addr(32'h4000)); exp_rbe.push_back(4'hF);
    exp_rdata.push_back(mem_data(next_addr(32'h4000)));
    wait_accept("both_rd_accept", acc_r);
    avs_read = 1'b0;
    check("both_read_after_write", 70'(acc_r - acc_w), 70'(2));
    wait_rdata();
    wait_idle(done);
    compare_all("both");

    // Reset while waiting for read data; late data must be ignored
    latency = 6;
    avs_read = 1'b1; avs_address = 32'h7000; avs_burstcount = 3'd2; avs_byteenable = 4'h3;
    wait_accept("rst_rd_accept", acc);
    avs_read = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    check("midrst_avs", 70'({avs_waitrequest, avs_readdatavalid, avs_readdata}), 70'(0));
    check("midrst_avm", {avm_address, avm_writedata, avm_byteenable, avm_write, avm_read}, 70'(0));
    prev_hold = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("postrst_quiet", 70'({avs_readdatavalid, avs_waitrequest, avm_read, avm_write}), 70'(0));
      cyc();
    end
    check("postrst_late_ignored", 70'(rdata_q.size()), 70'(0));
    clear_obs();
    resp_due_q.delete(); resp_data_q.delete();
    read_burst(32'h7100, 3'd3, 4'hC, 1, acc);
    compare_all("postrst_rd");

    // Random traffic with random downstream stalls
    rand_ws = 1'b1;
    for (int it = 0; it < 16; it++) begin
      ra  = $urandom;
      rbc = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0)
        write_burst(ra, rbc, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), acc, done);
      else
        read_burst(ra, rbc, 4'($urandom), int'($urandom_range(1, 4)), acc);
      compare_all("rand");
    end
    rand_ws = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
